// File: rtl/multi_input_selector.sv
// N-channel serial data selector: qualifies channels by rising-edge activity, drops idle ones,
// and hands the lowest-index active channel to the LED decoder through a glitch-free switch.
module multi_input_selector #(
    parameter int NUM_INPUTS     = 4,
    parameter int EDGE_THRESHOLD = 64,
    parameter int IDLE_TIMEOUT   = 256,
    parameter int GUARD_CYCLES   = 16,
    parameter int DEFAULT_CH     = NUM_INPUTS - 1,
    parameter int SEL_W          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] in,
    input  logic                  force_en,
    input  logic [SEL_W-1:0]      force_sel,
    output logic                  out,
    output logic [SEL_W-1:0]      sel,
    output logic [NUM_INPUTS-1:0] active,
    output logic                  switched
);

    localparam int CNT_W  = (EDGE_THRESHOLD > 0) ? $clog2(EDGE_THRESHOLD + 1) : 1;
    localparam int IDLE_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam int GRD_W  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(EDGE_THRESHOLD);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [GRD_W-1:0]  GRD_LAST = GRD_W'(GUARD_CYCLES - 1);
    localparam logic [SEL_W-1:0]  DEF_SEL  = SEL_W'(DEFAULT_CH);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [IDLE_W-1:0] sat_inc_idle(input logic [IDLE_W-1:0] v);
        return (v == IDLE_MAX) ? v : v + IDLE_W'(1);
    endfunction

    logic [NUM_INPUTS-1:0] last_in;
    logic [NUM_INPUTS-1:0] rise;
    logic [NUM_INPUTS-1:0] expire;
    logic [CNT_W-1:0]      cnt  [NUM_INPUTS];
    logic [IDLE_W-1:0]     idle [NUM_INPUTS];

    state_t                state, state_nxt;
    logic [GRD_W-1:0]      guard_cnt, guard_nxt;
    logic [SEL_W-1:0]      target;
    logic [SEL_W-1:0]      sel_nxt;
    logic                  force_ok;
    logic                  quiet;
    logic                  do_switch;

    assign rise = in & ~last_in;

    always_comb begin
        expire = '0;
        active = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            expire[i] = (IDLE_TIMEOUT != 0) && (idle[i] == IDLE_MAX);
            active[i] = (cnt[i] == CNT_MAX);
        end
    end

    // Activity tracking: an edge always beats an expiry landing on the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_in <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt[i]  <= '0;
                idle[i] <= '0;
            end
        end else begin
            last_in <= in;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (rise[i]) begin
                    cnt[i]  <= sat_inc_cnt(cnt[i]);
                    idle[i] <= '0;
                end else if (expire[i]) begin
                    cnt[i]  <= '0;
                    idle[i] <= '0;
                end else begin
                    idle[i] <= sat_inc_idle(idle[i]);
                end
            end
        end
    end

    // Target choice: lowest active index, unless the test override is engaged
    always_comb begin
        force_ok = ({1'b0, force_sel} < (SEL_W + 1)'(NUM_INPUTS));
        target   = DEF_SEL;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (active[i]) target = SEL_W'(i);
        end
        if (force_en) target = force_ok ? force_sel : DEF_SEL;
    end

    always_comb begin
        state_nxt = state;
        guard_nxt = guard_cnt;
        do_switch = 1'b0;
        quiet     = ~in[sel] & ~in[target];
        case (state)
            S_IDLE: begin
                if (target != sel) begin
                    if (force_en || quiet) begin
                        do_switch = 1'b1;
                    end else begin
                        state_nxt = S_PENDING;
                        guard_nxt = '0;
                    end
                end
            end
            S_PENDING: begin
                if (target == sel) begin
                    state_nxt = S_IDLE;
                end else if (force_en || quiet || guard_cnt == GRD_LAST) begin
                    do_switch = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    guard_nxt = guard_cnt + GRD_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        sel_nxt = do_switch ? target : sel;
    end

    // Selection and output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            guard_cnt <= '0;
            sel       <= DEF_SEL;
            switched  <= 1'b0;
            out       <= 1'b0;
        end else begin
            state     <= state_nxt;
            guard_cnt <= guard_nxt;
            sel       <= sel_nxt;
            switched  <= do_switch;
            out       <= in[sel_nxt];
        end
    end

endmodule
